// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, operation
// encodings, bit positions inside mstatus/mie/mip and mtvec mode codes.
package csr_pkg;

  localparam int COUNTER_W = 64;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // CSR instruction operation, taken from funct3[1:0]
  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_e;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Machine external interrupt bit in mie / mip
  localparam int MEI_BIT = 11;

  // mtvec MODE field
  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // Read-modify-write combine, computed at the widest legal XLEN; callers
  // truncate to their own width.
  function automatic logic [63:0] csr_rmw(input csr_op_e op,
                                          input logic [63:0] old_val,
                                          input logic [63:0] wdata);
    case (op)
      CSR_RW:  return wdata;
      CSR_RS:  return old_val | wdata;
      CSR_RC:  return old_val & ~wdata;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves. A write to
// either half takes priority over the increment for that cycle; the
// increment itself is a full 64-bit add so the low half carries into the high.
module csr_counter64
  import csr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          lo_data,
  input  logic [31:0]          hi_data,
  output logic [COUNTER_W-1:0] count
);

  // Count register: reset, then half writes, then increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= lo_data;
      if (wr_hi) count[63:32] <= hi_data;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file. Reads are combinational for the EX stage; every
// architectural update (CSR write, trap entry, mret, counters, mip sampling)
// happens at posedge clk under a synchronous active-low reset.
module csr_file
  import csr_pkg::*;
#(
  parameter int              XLEN         = 32,   // 32 or 64 only
  parameter logic [XLEN-1:0] HART_ID      = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
  parameter bit              HAS_COUNTERS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_req,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_write_en,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_req,
  input  logic            instret_inc,
  input  logic            irq_ext,
  output logic            irq_pending,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  // misa: MXL in the top two bits, I extension at bit 8
  localparam logic [1:0]      MXL      = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [XLEN-1:0] MISA_VAL = {MXL, {(XLEN-11){1'b0}}, 9'h100};

  // Architectural state
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_meie;
  logic            mip_meip;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [COUNTER_W-1:0] mcycle;
  logic [COUNTER_W-1:0] minstret;

  // Decode results
  logic [XLEN-1:0] rd_val;
  logic            mapped;
  logic            is_counter;
  logic            is_high;
  logic            is_ro;
  logic            wr_fire;
  logic [XLEN-1:0] wr_val;
  logic [31:0]     cnt_hi_data;
  logic            mcycle_wr_lo, mcycle_wr_hi;
  logic            minstret_wr_lo, minstret_wr_hi;
  logic [XLEN-1:0] mtvec_base;

  // Address decode and read mux
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can leave it unassigned and infer a latch.
    rd_val     = '0;
    mapped     = 1'b1;
    is_counter = 1'b0;
    is_high    = 1'b0;
    is_ro      = 1'b0;
    case (csr_addr)
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE]                   = mstatus_mie;
        rd_val[MSTATUS_MPIE]                  = mstatus_mpie;
        rd_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MISA: begin
        rd_val = MISA_VAL;
        is_ro  = 1'b1;
      end
      CSR_MIE:      rd_val[MEI_BIT] = mie_meie;
      CSR_MTVEC:    rd_val = mtvec;
      CSR_MSCRATCH: rd_val = mscratch;
      CSR_MEPC:     rd_val = mepc;
      CSR_MCAUSE:   rd_val = mcause;
      CSR_MTVAL:    rd_val = mtval;
      CSR_MIP: begin
        rd_val[MEI_BIT] = mip_meip;
        is_ro           = 1'b1;
      end
      CSR_MCYCLE, CSR_CYCLE: begin
        rd_val     = mcycle[XLEN-1:0];
        is_counter = 1'b1;
      end
      CSR_MINSTRET, CSR_INSTRET: begin
        rd_val     = minstret[XLEN-1:0];
        is_counter = 1'b1;
      end
      CSR_MCYCLEH, CSR_CYCLEH: begin
        rd_val     = XLEN'(mcycle[63:32]);
        is_counter = 1'b1;
        is_high    = 1'b1;
      end
      CSR_MINSTRETH, CSR_INSTRETH: begin
        rd_val     = XLEN'(minstret[63:32]);
        is_counter = 1'b1;
        is_high    = 1'b1;
      end
      CSR_MHARTID:  rd_val = HART_ID;
      default:      mapped = 1'b0;
    endcase
  end

  // Legality check and externally visible read data
  always_comb begin
    csr_illegal = csr_req & (~mapped
                             | (is_counter & ~HAS_COUNTERS)
                             | (is_high & (XLEN == 64))
                             | ((csr_addr[11:10] == 2'b11) & csr_write_en)
                             | (is_ro & csr_write_en));
    csr_rdata   = (csr_req && !csr_illegal) ? rd_val : '0;
  end

  // Write qualification: traps and mret pre-empt any CSR write this cycle
  always_comb begin
    wr_fire = csr_req & csr_write_en & (csr_op != CSR_NOP) & ~csr_illegal
              & ~trap_req & ~mret_req;
    wr_val  = XLEN'(csr_rmw(csr_op_e'(csr_op), 64'(rd_val), 64'(csr_wdata)));
  end

  // Counter write strobes; at XLEN=64 the low address covers both halves
  always_comb begin
    cnt_hi_data    = wr_val[XLEN-1:XLEN-32];
    mcycle_wr_lo   = wr_fire & (csr_addr == CSR_MCYCLE);
    minstret_wr_lo = wr_fire & (csr_addr == CSR_MINSTRET);
    if (XLEN == 64) begin
      mcycle_wr_hi   = mcycle_wr_lo;
      minstret_wr_hi = minstret_wr_lo;
    end else begin
      mcycle_wr_hi   = wr_fire & (csr_addr == CSR_MCYCLEH);
      minstret_wr_hi = wr_fire & (csr_addr == CSR_MINSTRETH);
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc     (1'b1),
    .wr_lo   (mcycle_wr_lo),
    .wr_hi   (mcycle_wr_hi),
    .lo_data (wr_val[31:0]),
    .hi_data (cnt_hi_data),
    .count   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc     (instret_inc),
    .wr_lo   (minstret_wr_lo),
    .wr_hi   (minstret_wr_hi),
    .lo_data (wr_val[31:0]),
    .hi_data (cnt_hi_data),
    .count   (minstret)
  );

  // mstatus interrupt-enable stack: trap pushes, mret pops, CSR write last
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, e.g. MPIE<=MIE and MIE<=0 in the same edge.
    if (!rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_req) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_req) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_fire && csr_addr == CSR_MSTATUS) begin
      mstatus_mie  <= wr_val[MSTATUS_MIE];
      mstatus_mpie <= wr_val[MSTATUS_MPIE];
    end
  end

  // Interrupt enable and external interrupt sampling
  always_ff @(posedge clk) begin
    if (!rst) begin
      mie_meie <= 1'b0;
      mip_meip <= 1'b0;
    end else begin
      mip_meip <= irq_ext;
      if (wr_fire && csr_addr == CSR_MIE) mie_meie <= wr_val[MEI_BIT];
    end
  end

  // Trap-state registers: trap entry overrides software writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      mepc   <= '0;
      mcause <= '0;
      mtval  <= '0;
    end else if (trap_req) begin
      mepc   <= {trap_pc[XLEN-1:2], 2'b00};
      mcause <= trap_cause;
      mtval  <= trap_tval;
    end else if (wr_fire) begin
      if (csr_addr == CSR_MEPC)   mepc   <= {wr_val[XLEN-1:2], 2'b00};
      if (csr_addr == CSR_MCAUSE) mcause <= wr_val;
      if (csr_addr == CSR_MTVAL)  mtval  <= wr_val;
    end
  end

  // Software-only registers; mtvec MODE values 2 and 3 are stored as direct
  always_ff @(posedge clk) begin
    if (!rst) begin
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
    end else if (wr_fire) begin
      if (csr_addr == CSR_MTVEC)
        mtvec <= {wr_val[XLEN-1:2],
                  (wr_val[1:0] == MTVEC_VECTORED) ? MTVEC_VECTORED : MTVEC_DIRECT};
      if (csr_addr == CSR_MSCRATCH) mscratch <= wr_val;
    end
  end

  // Redirect target and interrupt-pending indication
  always_comb begin
    mtvec_base     = {mtvec[XLEN-1:2], 2'b00};
    redirect_valid = trap_req | mret_req;
    redirect_pc    = '0;
    if (trap_req) begin
      if (mtvec[1:0] == MTVEC_VECTORED && trap_cause[XLEN-1])
        redirect_pc = mtvec_base + {trap_cause[XLEN-3:0], 2'b00};
      else
        redirect_pc = mtvec_base;
    end else if (mret_req) begin
      redirect_pc = mepc;
    end
    irq_pending = mstatus_mie & mie_meie & mip_meip;
  end

endmodule
